// File: rtl/uart_pkg.sv
// Shared UART receive-buffer definitions: sizes, controller state encoding
// and the layout of one buffer entry.
package uart_pkg;

  localparam int unsigned BUF_DEPTH = 256;
  localparam int unsigned ADDR_W    = $clog2(BUF_DEPTH);
  localparam int unsigned DATA_W    = 8;
  // Occupancy needs one extra bit to represent a completely full buffer.
  localparam int unsigned CNT_W     = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CLEAR = 2'd2
  } rxbuf_state_e;

  // One buffer entry as stored in the array: {byte, valid}.
  typedef struct packed {
    logic [DATA_W-1:0] rx_byte;
    logic              valid;
  } rxbuf_entry_t;

endpackage

// File: rtl/uart_rxbuf_ctrl.sv
// Sequencing controller for the UART receive buffer.
// Accepts bytes from the RX deserializer and issues buffer writes, serves
// one-at-a-time host pops, and tracks occupancy, overflow and read errors.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   rx_valid_i, rx_data_i      received byte strobe and payload
//   pop_i / pop_ready_o        host pop request handshake
//   pop_valid_o, pop_data_o,
//   pop_empty_o                pop response (pulse), byte, empty indication
//   clr_i                      flush buffer and controller state
//   wmark_i                    occupancy watermark (0 = off)
//   count_o, full_o, empty_o   occupancy status
//   ovf_o, rd_err_o            sticky overflow / invalid-entry read flags
//   buf_*                      buffer array write/read/clear interface
//   wmark_irq_o                watermark interrupt (only with UART_RXBUF_WMARK_EN)
//
// Optional feature macro: UART_RXBUF_WMARK_EN adds the registered wmark_irq_o.
module uart_rxbuf_ctrl
  import uart_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              pop_i,
  output logic              pop_ready_o,
  output logic              pop_valid_o,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              pop_empty_o,
  input  logic              clr_i,
  input  logic [CNT_W-1:0]  wmark_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              ovf_o,
  output logic              rd_err_o,
`ifdef UART_RXBUF_WMARK_EN
  output logic              wmark_irq_o,
`endif
  output logic              buf_we_o,
  output logic [ADDR_W-1:0] buf_waddr_o,
  output logic [DATA_W-1:0] buf_wdata_o,
  output logic [CNT_W-1:0]  buf_raddr_o,
  output logic              buf_clr_o,
  input  logic [DATA_W:0]   buf_rdata_i
);

  rxbuf_state_e      state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              rd_err_q, rd_err_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              pop_valid_q, pop_valid_d;
  logic              pop_empty_q, pop_empty_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              pop_ready_q, pop_ready_d;
  logic [CNT_W-1:0]  buf_raddr_q, buf_raddr_d;
  logic              buf_clr_q, buf_clr_d;
  logic              wr_en_c;
  logic              wr_drop_c;
  logic              pop_commit_c;
  rxbuf_entry_t      rd_entry;

  assign rd_entry = rxbuf_entry_t'(buf_rdata_i);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a clear request wins over any pop activity.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d = CLEAR;
        end else if (pop_i) begin
          state_d = READ;
        end
      end
      READ:    state_d = clr_i ? CLEAR : IDLE;
      CLEAR:   state_d = clr_i ? CLEAR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    ovf_d       = ovf_q;
    rd_err_d    = rd_err_q;
    pop_valid_d = 1'b0;
    pop_empty_d = 1'b0;
    pop_data_d  = pop_data_q;

    // A byte arriving during a flush (request cycle or CLEAR cycle) is
    // discarded silently; only a genuinely full buffer counts as overflow.
    // Full is judged on the registered count, so a same-cycle pop does not
    // make room for it.
    wr_en_c      = rx_valid_i && !clr_i && (state_q != CLEAR) && !full_q;
    wr_drop_c    = rx_valid_i && !clr_i && (state_q != CLEAR) && full_q;
    pop_commit_c = (state_q == READ) && !clr_i && (count_q != '0);

    if (wr_en_c) begin
      wptr_d = wptr_q + ADDR_W'(1);
    end
    if (wr_drop_c) begin
      ovf_d = 1'b1;
    end

    if ((state_q == READ) && !clr_i) begin
      pop_valid_d = 1'b1;
      if (count_q == '0) begin
        pop_empty_d = 1'b1;
        pop_data_d  = '0;
      end else begin
        pop_data_d = rd_entry.rx_byte;
        rptr_d     = rptr_q + ADDR_W'(1);
        if (!rd_entry.valid) begin
          rd_err_d = 1'b1;
        end
      end
    end

    count_d = count_q + CNT_W'(wr_en_c) - CNT_W'(pop_commit_c);

    if (state_q == CLEAR) begin
      wptr_d   = '0;
      rptr_d   = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      rd_err_d = 1'b0;
    end

    full_d      = (count_d == CNT_W'(BUF_DEPTH));
    empty_d     = (count_d == '0);
    pop_ready_d = (state_d == IDLE);
    buf_clr_d   = (state_d == CLEAR);
    // Outside READ the read address points past the array so it reads zero.
    buf_raddr_d = (state_d == READ) ? {1'b0, rptr_d} : CNT_W'(BUF_DEPTH);
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      rd_err_q    <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      pop_valid_q <= 1'b0;
      pop_empty_q <= 1'b0;
      pop_data_q  <= '0;
      pop_ready_q <= 1'b1;
      buf_raddr_q <= CNT_W'(BUF_DEPTH);
      buf_clr_q   <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      rd_err_q    <= rd_err_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      pop_valid_q <= pop_valid_d;
      pop_empty_q <= pop_empty_d;
      pop_data_q  <= pop_data_d;
      pop_ready_q <= pop_ready_d;
      buf_raddr_q <= buf_raddr_d;
      buf_clr_q   <= buf_clr_d;
    end
  end

`ifdef UART_RXBUF_WMARK_EN
  logic wmark_irq_q, wmark_irq_d;

  // Watermark tracks the same count value that count_o will show.
  assign wmark_irq_d = (wmark_i != '0) && (count_d >= wmark_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wmark_irq_q <= 1'b0;
    end else begin
      wmark_irq_q <= wmark_irq_d;
    end
  end

  assign wmark_irq_o = wmark_irq_q;
`else
  logic wmark_unused;
  assign wmark_unused = ^wmark_i;
`endif

  assign pop_ready_o = pop_ready_q;
  assign pop_valid_o = pop_valid_q;
  assign pop_data_o  = pop_data_q;
  assign pop_empty_o = pop_empty_q;
  assign count_o     = count_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign ovf_o       = ovf_q;
  assign rd_err_o    = rd_err_q;
  assign buf_we_o    = wr_en_c;
  assign buf_waddr_o = wptr_q;
  assign buf_wdata_o = rx_data_i;
  assign buf_raddr_o = buf_raddr_q;
  assign buf_clr_o   = buf_clr_q;

endmodule
